mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 16x16 shift-add multiplier between NREQ requesters (e.g. CPU peripheral port and an accelerator).
- Captures the granted requester's operands, pulses the multiplier's init, waits for its done, returns the 32-bit product, then waits for done to drop before the next issue.
- Includes a watchdog so a hung multiplier cannot lock out the requesters.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 1023, max cycles in WAIT_DONE before the transaction is aborted with error.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level; hold high with stable operands until ack
- op_a  input  16*NREQ  operand A, slice i = op_a[16*i+15:16*i]
- op_b  input  16*NREQ  operand B, same slicing
- gnt  output  NREQ  one-hot; the requester currently owning the multiplier
- ack  output  NREQ  one-hot, one-cycle completion pulse
- result  output  32  product of the last completed transaction
- err  output  1  high in the ack cycle if that transaction timed out
- busy  output  1  high whenever state != IDLE
- mult_init  output  1  init to the multiplier
- mult_op_A  output  16  operand A to the multiplier
- mult_op_B  output  16  operand B to the multiplier
- mult_done  input  1  done from the multiplier
- mult_result  input  32  result from the multiplier

Behaviour:
- Reset (async): state=IDLE; gnt=0, ack=0, result=0, err=0, mult_init=0, mult_op_A/B=0, timer=0, rr pointer=NREQ-1 (requester 0 wins first).
- All outputs registered.
- IDLE:
  - If any req bit is set and mult_done=0: choose the first set bit searching from pointer+1 modulo NREQ.
  - Set gnt one-hot, latch that requester's op_a/op_b into mult_op_A/B, set pointer to the winner, go to ISSUE.
  - If mult_done=1 (multiplier still in its done-hold window), stay in IDLE.
- ISSUE (1 cycle): mult_init=1. Go to WAIT_DONE and clear timer.
- WAIT_DONE:
  - mult_init=0; timer increments each cycle.
  - If mult_done=1: latch result=mult_result, err=0, go to RESPOND.
  - Else if timer==TIMEOUT: result=0, err=1, go to RESPOND.
- RESPOND (1 cycle): ack[winner]=1, go to RELEASE. result and err stay valid from this cycle until the next RESPOND.
- RELEASE:
  - ack=0, gnt=0.
  - Wait until mult_done=0, then go to IDLE. This ensures the multiplier is back in START before the next init; its done is held high for about 30 cycles after completion.
  - On the error path mult_done is already 0, so RELEASE lasts one cycle.
- Request rules:
  - Operands are sampled only in the IDLE->ISSUE cycle; later changes to op_a/op_b have no effect.
  - Once granted, a transaction always completes and acks, even if req drops. The requester must ignore an ack it did not expect.
  - A req deasserted before grant is simply never served.
- Simultaneous requests: exactly one grant per transaction. After a transaction by i, requester i has the lowest priority; no starvation.
- Arithmetic: no computation in the block; mult_op_A/B and result are pass-through registers, unsigned.
- Latency, req high -> ack = 3 + multiplier compute cycles. Minimum spacing between two ack pulses = 2 + done-hold + compute.
- Reset mid-operation: everything returns to reset values immediately. No ack is issued for the aborted transaction; the multiplier shares the same reset.
- gnt and ack are never asserted for more than one requester at a time.

Test Plan:
- Single request: req0 with A=3, B=5 -> one mult_init pulse, ack[0] one cycle, result=15, err=0, gnt returns to 0.
- Simultaneous requests after reset: req=2'b11, req0 A=0xFFFF B=0xFFFF, req1 A=7 B=9.
  - ack[0] first with result=0xFFFE0001.
  - ack[1] next with result=63, issued only after mult_done has fallen.
- Fairness: both req held high continuously for 4 transactions -> ack order 0,1,0,1; no second mult_init while mult_done=1.
- Zero operand: A=1234, B=0 -> result=0, ack asserted, err=0.
- Timeout: multiplier model with mult_done stuck at 0, TIMEOUT=15 -> ack after 15 WAIT_DONE cycles with err=1, result=0; next request is accepted normally.
- Reset mid-operation: assert reset during WAIT_DONE -> gnt=0, ack never pulses, busy=0. A new request after reset completes correctly, e.g. 2*8=16.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer that lends one shared shift-add multiplier to
// NREQ requesters, with a watchdog that aborts a transaction whose done never arrives.
module mult_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   op_a,
  input  logic [16*NREQ-1:0]   op_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic                 mult_init,
  output logic [15:0]          mult_op_A,
  output logic [15:0]          mult_op_B,
  input  logic                 mult_done,
  input  logic [31:0]          mult_result
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESPOND, RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, win;
  logic            found;
  logic [TW-1:0]   timer, timer_n, timer_inc;
  logic [NREQ-1:0] gnt_n, ack_n;
  logic [31:0]     result_n;
  logic            err_n, busy_n, init_n;
  logic [15:0]     opa_n, opb_n, sel_a, sel_b;
  int              idx;

  // Search starts one past the last winner so the previous owner ranks lowest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_a = op_a[16*i +: 16];
        sel_b = op_b[16*i +: 16];
      end
    end
  end

  assign timer_inc = timer + TW'(1);

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    timer_n  = timer;
    gnt_n    = gnt;
    ack_n    = '0;
    result_n = result;
    err_n    = err;
    init_n   = 1'b0;
    opa_n    = mult_op_A;
    opb_n    = mult_op_B;
    case (state)
      IDLE: begin
        // A still-high done means the multiplier has not yet returned to START.
        if (found && !mult_done) begin
          state_n = ISSUE;
          gnt_n   = NREQ'(1) << win;
          ptr_n   = win;
          opa_n   = sel_a;
          opb_n   = sel_b;
          init_n  = 1'b1;
        end
      end
      ISSUE: begin
        state_n = WAIT_DONE;
        timer_n = '0;
      end
      WAIT_DONE: begin
        timer_n = timer_inc;
        if (mult_done) begin
          state_n  = RESPOND;
          result_n = mult_result;
          err_n    = 1'b0;
          ack_n    = gnt;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          state_n  = RESPOND;
          result_n = '0;
          err_n    = 1'b1;
          ack_n    = gnt;
        end
      end
      RESPOND: begin
        state_n = RELEASE;
        gnt_n   = '0;
      end
      RELEASE: begin
        if (!mult_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      timer     <= '0;
      gnt       <= '0;
      ack       <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mult_init <= 1'b0;
      mult_op_A <= '0;
      mult_op_B <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      timer     <= timer_n;
      gnt       <= gnt_n;
      ack       <= ack_n;
      result    <= result_n;
      err       <= err_n;
      busy      <= busy_n;
      mult_init <= init_n;
      mult_op_A <= opa_n;
      mult_op_B <= opb_n;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: vector table plus hand sequences for fairness, timeout
// and mid-transaction reset, against a behavioural multiplier with a done-hold window.
module tb_mult_arbiter;

  localparam int TIMEOUT = 15;
  localparam int COMPUTE = 5;
  localparam int HOLD    = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [1:0]  gnt, ack;
  logic [31:0] result;
  logic        err, busy, mult_init;
  logic [15:0] mult_op_A, mult_op_B;
  logic        mult_done;
  logic [31:0] mult_result;

  mult_arbiter #(.NREQ(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .ack(ack), .result(result), .err(err), .busy(busy),
    .mult_init(mult_init), .mult_op_A(mult_op_A), .mult_op_B(mult_op_B),
    .mult_done(mult_done), .mult_result(mult_result)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // multiplier model: COMPUTE cycles after init, done held for HOLD cycles
  logic        stuck = 1'b0;
  logic [1:0]  ph;
  logic [7:0]  mcnt;
  logic [31:0] prod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph <= 0; mcnt <= 0; prod <= 0; mult_done <= 0; mult_result <= 0;
    end else begin
      case (ph)
        2'd0: if (mult_init && !stuck) begin
          prod <= {16'h0, mult_op_A} * {16'h0, mult_op_B};
          mcnt <= 8'(COMPUTE); ph <= 2'd1;
        end
        2'd1: if (mcnt == 1) begin
          mult_done <= 1'b1; mult_result <= prod; mcnt <= 8'(HOLD); ph <= 2'd2;
        end else mcnt <= mcnt - 1;
        default: if (mcnt == 1) begin
          mult_done <= 1'b0; ph <= 2'd0;
        end else mcnt <= mcnt - 1;
      endcase
    end
  end

  // scoreboard: {err, idx, result}
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  int ack_cnt = 0;
  int init_cyc = 0;
  int ack_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    logic [1:0]  exp_ack;
    if (!reset) begin
      if (mult_init) begin
        init_cyc = cyc;
        check("init_while_done", mult_done, 0);
      end
      if (ack != 2'b00) begin
        ack_cyc = cyc;
        ack_cnt++;
        check("ack_onehot", $countones(ack), 1);
        check("gnt_eq_ack", gnt, ack);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack=%b with nothing expected", ack);
        end else begin
          e = exp_q.pop_front();
          exp_ack = 2'b01 << e[32];
          check("ack_idx", ack, exp_ack);
          check("result", result, e[31:0]);
          check("err", err, e[33]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [1:0] r, input logic [15:0] a0, b0, a1, b1);
    req = r; op_a = {a1, a0}; op_b = {b1, b0};
  endtask

  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (ack_cnt < target && n < 500) begin
      @(negedge clk); #1; n++;
    end
    check(name, ack_cnt >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic        exp_idx;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int base, saved, n;
    vecs[0] = '{2'b01, 16'd3,    16'd5, 16'd0,    16'd0, 1'b0, 32'd15,      1'b0};
    vecs[1] = '{2'b01, 16'd1234, 16'd0, 16'd0,    16'd0, 1'b0, 32'd0,       1'b0};
    vecs[2] = '{2'b10, 16'd0,    16'd0, 16'd2,    16'd8, 1'b1, 32'd16,      1'b0};
    vecs[3] = '{2'b10, 16'd0,    16'd0, 16'hFFFF, 16'd2, 1'b1, 32'h0001FFFE, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_init", mult_init, 0);
    check("rst_opA", mult_op_A, 0);
    check("rst_opB", mult_op_B, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_idx, vecs[i].exp_res});
      base = ack_cnt;
      drive(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      wait_acks(base + 1, "vec_ack_wait");
      req = 2'b00;
      @(negedge clk); #1;
      check("gnt_release", gnt, 0);
      check("ack_single_cycle", ack, 0);
    end

    // simultaneous requests straight after reset: requester 0 first
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 32'hFFFE0001});
    exp_q.push_back({1'b0, 1'b1, 32'd63});
    base = ack_cnt;
    drive(2'b11, 16'hFFFF, 16'hFFFF, 16'd7, 16'd9);
    wait_acks(base + 1, "sim_ack0_wait");
    req[0] = 1'b0;
    wait_acks(base + 2, "sim_ack1_wait");
    req = 2'b00;

    // fairness with both held continuously
    for (int k = 0; k < 4; k++)
      exp_q.push_back({1'b0, k[0], k[0] ? 32'd63 : 32'd15});
    base = ack_cnt;
    drive(2'b11, 16'd3, 16'd5, 16'd7, 16'd9);
    wait_acks(base + 4, "fair_ack_wait");
    req = 2'b00;

    // timeout on a stuck multiplier, then normal service
    stuck = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'd0});
    base = ack_cnt;
    drive(2'b01, 16'd5, 16'd5, 16'd0, 16'd0);
    wait_acks(base + 1, "tmo_ack_wait");
    check("tmo_latency", ack_cyc - init_cyc, TIMEOUT + 1);
    req = 2'b00;
    stuck = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 32'd42});
    drive(2'b10, 16'd0, 16'd0, 16'd6, 16'd7);
    wait_acks(base + 2, "post_tmo_ack_wait");
    req = 2'b00;

    // reset while waiting for done
    repeat (HOLD + 5) @(negedge clk);
    saved = ack_cnt;
    drive(2'b01, 16'd100, 16'd100, 16'd0, 16'd0);
    n = 0;
    while (!mult_init && n < 100) begin @(negedge clk); n++; end
    check("abort_init_seen", mult_init, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    check("abort_gnt", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_ack", ack_cnt, saved);
    exp_q.push_back({1'b0, 1'b0, 32'd16});
    drive(2'b01, 16'd2, 16'd8, 16'd0, 16'd0);
    wait_acks(saved + 1, "post_abort_ack_wait");
    req = 2'b00;

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
